// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared state encoding and constants for the LED PWM driver
package led_pwm_pkg;

    localparam int DUTY_W = 8;
    localparam logic [DUTY_W-1:0] PWM_MAX = 8'd254;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/led_pwm_tick.sv
// led_pwm_tick: prescaler emitting one tick every PRESCALE clocks while clr is low
module led_pwm_tick #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] pre_cnt;

    assign tick = !clr && (pre_cnt == CW'(PRESCALE - 1));

    // divider counts 0..PRESCALE-1 and is parked at zero while cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre_cnt <= '0;
        else
            pre_cnt <= (clr || tick) ? '0 : pre_cnt + 1'b1;
    end

endmodule

// File: rtl/led_pwm_drv.sv
// led_pwm_drv: 255-step LED PWM with shadowed duty; LED_PWM_PRESCALE_EN adds a tick prescaler
module led_pwm_drv
    import led_pwm_pkg::*;
`ifdef LED_PWM_PRESCALE_EN
#(
    parameter int PRESCALE = 4
)
`endif
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              duty_valid,
    output logic              duty_ready,
    output logic              pwm_out,
    output logic              period_start
);

    state_t            state, state_nxt;
    logic [DUTY_W-1:0] pwm_cnt, duty_act, shadow;
    logic              shadow_full;
    logic              tick, run, entry, bnd, load, xfer;

`ifdef LED_PWM_PRESCALE_EN
    led_pwm_tick #(.PRESCALE(PRESCALE)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (!run),
        .tick (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // run: staying in RUN this edge; entry: leaving IDLE this edge
    assign run        = (state == RUN) && en;
    assign entry      = (state == IDLE) && en;
    assign bnd        = run && tick && (pwm_cnt == PWM_MAX);
    assign load       = (entry || bnd) && shadow_full;
    assign xfer       = duty_valid && !shadow_full;
    assign duty_ready = !shadow_full;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // state follows en on every edge
    always_comb begin
        state_nxt = en ? RUN : IDLE;
    end

    // period counter, registered compare and period marker; all cleared outside RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt      <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            pwm_cnt      <= !run ? '0 : !tick ? pwm_cnt : bnd ? '0 : pwm_cnt + 1'b1;
            pwm_out      <= run && (pwm_cnt < duty_act);
            period_start <= entry || bnd;
        end
    end

    // shadow accepts while empty; active duty only changes at a boundary or RUN entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_act    <= '0;
            shadow      <= '0;
            shadow_full <= 1'b0;
        end else begin
            if (load)
                duty_act <= shadow;
            if (xfer)
                shadow <= duty_in;
            shadow_full <= xfer || (shadow_full && !load);
        end
    end

endmodule

// File: tb/tb_led_pwm_drv.sv
// tb_led_pwm_drv: directed plus random bench with a time-based reference model for led_pwm_drv
module tb_led_pwm_drv;

`ifdef LED_PWM_PRESCALE_EN
    localparam int P = 4;
`else
    localparam int P = 1;
`endif
    localparam int PER = 255 * P;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       duty_valid = 1'b0;
    logic [7:0] duty_in = 8'd0;
    logic       duty_ready, pwm_out, period_start;

    int checks = 0;
    int errors = 0;
    int hi_cnt = 0;
    int ps_cnt = 0;

    bit m_run, m_full, m_pwm, m_ps, m_acc;
    int m_n, m_duty, m_sh;

    always #5 clk = ~clk;

`ifdef LED_PWM_PRESCALE_EN
    led_pwm_drv #(.PRESCALE(P)) dut (
`else
    led_pwm_drv dut (
`endif
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .pwm_out     (pwm_out),
        .period_start(period_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_full = 0; m_pwm = 0; m_ps = 0; m_acc = 0;
        m_n = 0; m_duty = 0; m_sh = 0;
    endtask

    // model time since RUN entry: counter value = (n/P) mod 255, boundary every 255*P clocks
    task automatic step();
        bit xfer;
        @(posedge clk);
        xfer  = duty_valid && !m_full;
        m_acc = xfer;
        if (en && !m_run) begin
            m_n = 0; m_pwm = 0; m_ps = 1;
            if (m_full) begin m_duty = m_sh; m_full = 0; end
        end else if (en) begin
            m_pwm = ((m_n / P) % 255) < m_duty;
            m_n++;
            m_ps = (m_n % PER) == 0;
            if (m_ps && m_full) begin m_duty = m_sh; m_full = 0; end
        end else begin
            m_pwm = 0; m_ps = 0;
        end
        if (xfer) begin m_sh = duty_in; m_full = 1; end
        m_run = en;
        @(negedge clk);
        chk("pwm_out", pwm_out, m_pwm);
        chk("period_start", period_start, m_ps);
        chk("duty_ready", duty_ready, !m_full);
        hi_cnt += int'(pwm_out);
        ps_cnt += int'(period_start);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input int d);
        int k;
        duty_valid = 1'b1;
        duty_in    = 8'(d);
        k = 0;
        do begin step(); k++; end while (!m_acc && k < 2 * PER + 4);
        if (!m_acc) chk("load_timeout", 0, 1);
        duty_valid = 1'b0;
    endtask

    task automatic window(input int d, input int nper, input string tag);
        hi_cnt = 0;
        ps_cnt = 0;
        run(nper * PER);
        chk({tag, "_high_clks"}, hi_cnt, d * P * nper);
        chk({tag, "_periods"}, ps_cnt, nper);
    endtask

    initial begin
        int k;
        model_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_ps", period_start, 0);
        chk("rst_ready", duty_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        load(128);
        chk("idle_shadow_full", duty_ready, 0);
        en = 1'b1;
        step();
        chk("entry_ps", period_start, 1);
        run(PER - 1);
        window(128, 1, "d128");

        load(0);
        run(PER + 2);
        window(0, 3, "d0");
        load(255);
        run(PER + 2);
        window(255, 3, "d255");

        run(PER / 2);
        load(50);
        load(60);
        run(2 * PER);
        window(60, 1, "d60");

        k = 0;
        while (((m_n / P) % 255) != 100 && k < PER + 4) begin step(); k++; end
        chk("reach_cnt100", (m_n / P) % 255, 100);
        en = 1'b0;
        step();
        chk("drop_pwm", pwm_out, 0);
        run(5);
        en = 1'b1;
        step();
        chk("reen_ps", period_start, 1);
        run(3 * P);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 4) == 0) en = ~en;
            duty_valid = 1'($urandom_range(0, 1));
            duty_in    = 8'($urandom_range(0, 255));
            run($urandom_range(1, 400));
            duty_valid = 1'b0;
        end

        en = 1'b1;
        run(PER / 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pwm", pwm_out, 0);
        chk("async_rst_ps", period_start, 0);
        chk("async_rst_ready", duty_ready, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(PER);
        load(10);
        run(PER + 2);
        window(10, 1, "d10");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
